clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
Consumer-side checker for the even clock divider outputs (clk_div2/4/10 style). It samples one divided clock in the source clk domain and measures its period and high time in clk cycles. It compares the measured ratio against a programmed expected divisor and reports lock, mismatch and stall status. Instantiate one per divided clock under test, on the same clk/rstn as the divider.

Parameters:
CNT_W, 8, width of period/high counters and of exp_div; counters saturate at 2^CNT_W-1
LOCK_CNT, 4, consecutive matching periods required to assert locked (1..15)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  source clock, the same clock that drives the divider
rstn  input  1  asynchronous active-low reset
div_in  input  1  divided clock under test, sampled as data on clk rising edge
exp_div  input  CNT_W  expected division ratio; 0 = checking disabled (measure only)
clr  input  1  synchronous clear: err_cnt=0, FSM to IDLE, status cleared
meas_div  output  CNT_W  last measured period in clk cycles
meas_high  output  CNT_W  last measured high time in clk cycles
meas_valid  output  1  1-cycle pulse when meas_div is updated
locked  output  1  LOCK_CNT consecutive periods matched exp_div with 50% duty
mismatch  output  1  1-cycle pulse on a failing period check
stall  output  1  sticky; period counter saturated with no rising edge
err_cnt  output  ERR_W  saturating count of mismatch pulses

Behaviour:
- Reset (rstn=0, async): all outputs 0, state IDLE, all counters 0.
- Edge detect: div_q registers the previous sample. rise = div_s & ~div_q; fall = ~div_s & div_q. div_s = div_in, or the synchronized value (see Optional Feature).
- Period counter: set to 1 on a rise cycle; otherwise increment, saturating at max. Example: a div2 input gives 2, a div10 input gives 10.
- High counter: set to 1 on a rise cycle. Increment while div_s=1 and not rise, saturating. On fall: meas_high <= high counter.
- FSM states: IDLE, ACQ, TRACK, LOCKED.
  - IDLE: on rise -> ACQ. No measurement is made on this edge.
  - ACQ: on rise -> meas_div <= period counter, meas_valid pulse, run the check, -> TRACK.
  - TRACK/LOCKED: on each rise, latch the measurement, pulse meas_valid, run the check.
- Check: applies only when exp_div != 0. Pass = (meas_div == exp_div) AND (2*meas_high == meas_div). The high value used is the one latched at the preceding fall.
  - Pass: match_cnt++ (saturating at LOCK_CNT). When it reaches LOCK_CNT -> LOCKED, locked=1 on the next cycle.
  - Fail: mismatch pulse, err_cnt++ (saturating), match_cnt=0, locked=0, state -> TRACK.
- exp_div=0: measurements still reported, mismatch never pulses, locked stays 0.
- Stall: period counter reaches max in any state other than IDLE -> stall=1 (sticky until clr/reset), locked=0, match_cnt=0, state -> IDLE.
- clr has priority over all same-cycle events. It clears err_cnt, stall, locked, match_cnt and the state. meas_div and meas_high hold.
- A change to exp_div mid-run takes effect at the next check; no implicit clear.
- Simultaneous rise and counter saturation: rise wins, and the saturated value is measured (fails the check if exp_div != max).

Optional Feature:
Macro DIV_MON_SYNC_EN.
- Defined: div_in passes through a 2-flop synchronizer (reset to 0) before edge detect. Use when div_in is not clk-synchronous, e.g. a ripple-clocked div4. Adds 2 cycles of detection latency; measured values are unchanged.
- Undefined: div_in is sampled directly (div_s = div_in); single-flop edge detect only.

Test Plan:
- div_in toggling every clk, exp_div=2 -> meas_div=2, meas_high=1 each period. locked=1 one cycle after the 4th meas_valid (5th rise). mismatch never pulses.
- 5-high/5-low pattern, exp_div=10 -> meas_div=10, meas_high=5, locked after 4 checks. Then set exp_div=4 -> mismatch pulse every 10 cycles, err_cnt 1,2,3..., locked=0.
- 3-high/7-low pattern, exp_div=10 -> meas_div=10, meas_high=3, mismatch on every period, never locked.
- Lock reached, then div_in held low for 255+ cycles (CNT_W=8) -> stall=1, locked=0, state IDLE. Toggling resumes -> relock after 5 rises. clr -> stall=0, err_cnt=0.
- err_cnt driven to 255 with forced mismatches -> holds at 255. clr asserted on the same cycle as a mismatch -> err_cnt=0, no pulse.
- rstn pulsed low mid-period while LOCKED -> all outputs 0 immediately; after release, the first meas_valid comes on the 2nd rise.

Source files
------------

// File: rtl/clk_div_monitor.sv
// Period / duty-cycle checker for one divided clock sampled in its source clk domain.
// Optional DIV_MON_SYNC_EN: adds a 2-flop synchronizer on div_in before edge detect.
module clk_div_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_div,
    input  logic             clr,
    output logic [CNT_W-1:0] meas_div,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             stall,
    output logic [ERR_W-1:0] err_cnt
);
    // state     | meaning
    // ST_IDLE   | waiting for a first rising edge, nothing measured yet
    // ST_ACQ    | one edge seen, next edge gives the first full period
    // ST_TRACK  | measuring and checking every period, not yet locked
    // ST_LOCKED | LOCK_CNT consecutive periods passed the check

    typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_TRACK, ST_LOCKED} state_t;

    localparam int               MATCH_W  = 5;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);

    state_t             state;
    logic               div_s;
    logic               div_q;
    logic               rise;
    logic               fall;
    logic [CNT_W-1:0]   period_cnt;
    logic [CNT_W-1:0]   high_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_nxt;
    logic [CNT_W:0]     high_x2;
    logic               check_pass;
    logic               period_sat;

`ifdef DIV_MON_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= div_in;
            sync_q2 <= sync_q1;
        end
    end

    assign div_s = sync_q2;
`else
    assign div_s = div_in;
`endif

    assign rise = div_s & ~div_q;
    assign fall = ~div_s & div_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q      <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            meas_high  <= '0;
        end else begin
            div_q <= div_s;
            if (rise)
                period_cnt <= CNT_ONE;
            else if (period_cnt != CNT_MAX)
                period_cnt <= period_cnt + 1'b1;
            if (rise)
                high_cnt <= CNT_ONE;
            else if (div_s && (high_cnt != CNT_MAX))
                high_cnt <= high_cnt + 1'b1;
            if (fall)
                meas_high <= high_cnt;
        end
    end

    // meas_high still holds the high time latched at the fall inside the period just ending
    assign high_x2    = {meas_high, 1'b0};
    assign check_pass = (period_cnt == exp_div) && (high_x2 == {1'b0, period_cnt});
    assign period_sat = (period_cnt == CNT_MAX);
    assign match_nxt  = match_cnt + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            meas_div   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            stall      <= 1'b0;
            err_cnt    <= '0;
            match_cnt  <= '0;
        end else begin
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;
            if (clr) begin
                state     <= ST_IDLE;
                locked    <= 1'b0;
                stall     <= 1'b0;
                err_cnt   <= '0;
                match_cnt <= '0;
            end else if (rise) begin
                if (state == ST_IDLE) begin
                    state <= ST_ACQ;
                end else begin
                    meas_div   <= period_cnt;
                    meas_valid <= 1'b1;
                    if (exp_div == '0) begin
                        state     <= ST_TRACK;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                    end else if (check_pass) begin
                        // locked follows the LOCKED state one cycle later
                        locked <= (state == ST_LOCKED);
                        if (match_nxt >= LOCK_TGT) begin
                            match_cnt <= LOCK_TGT;
                            state     <= ST_LOCKED;
                        end else begin
                            match_cnt <= match_nxt;
                            state     <= ST_TRACK;
                        end
                    end else begin
                        mismatch  <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        state     <= ST_TRACK;
                        if (err_cnt != ERR_MAX)
                            err_cnt <= err_cnt + 1'b1;
                    end
                end
            end else if (period_sat && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                stall     <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
            end else begin
                locked <= (state == ST_LOCKED);
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor; expected values are hand-derived per pattern.
module tb_clk_div_monitor;

`ifdef DIV_MON_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       div_in;
    logic       clr;
    logic [7:0] exp_div;
    logic [7:0] meas_div;
    logic [7:0] meas_high;
    logic       meas_valid;
    logic       locked;
    logic       mismatch;
    logic       stall;
    logic [7:0] err_cnt;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_valid = 0;
    int n_mism  = 0;
    int base_v;
    int base_m;

    clk_div_monitor #(.CNT_W(8), .LOCK_CNT(4), .ERR_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .div_in     (div_in),
        .exp_div    (exp_div),
        .clr        (clr),
        .meas_div   (meas_div),
        .meas_high  (meas_high),
        .meas_valid (meas_valid),
        .locked     (locked),
        .mismatch   (mismatch),
        .stall      (stall),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (meas_valid) n_valid++;
        if (mismatch)   n_mism++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_pattern(input int hi, input int lo, input int nper);
        for (int p = 0; p < nper; p++) begin
            for (int c = 0; c < hi + lo; c++) begin
                div_in = (c < hi);
                step();
            end
        end
    endtask

    task automatic settle();
        div_in = 1'b0;
        repeat (LAT + 1) step();
    endtask

    task automatic restart(input logic [7:0] ed);
        div_in = 1'b0;
        repeat (4) step();
        clr = 1'b1;
        step();
        clr     = 1'b0;
        exp_div = ed;
        base_v  = n_valid;
        base_m  = n_mism;
    endtask

    initial begin
        rstn    = 1'b0;
        div_in  = 1'b0;
        clr     = 1'b0;
        exp_div = 8'd0;
        repeat (3) step();
        check_val("rst_meas_div", int'(meas_div), 0);
        check_val("rst_meas_valid", int'(meas_valid), 0);
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_stall", int'(stall), 0);
        check_val("rst_err_cnt", int'(err_cnt), 0);
        rstn = 1'b1;
        repeat (3) step();

        // div2 toggle: 5th rise gives 4th pass, locked one cycle later
        exp_div = 8'd2;
        base_v  = n_valid;
        base_m  = n_mism;
        for (int i = 0; i < 12; i++) begin
            div_in = (i % 2 == 0);
            step();
            if (i == 8 + LAT) begin
                check_val("div2_valid_5th_rise", int'(meas_valid), 1);
                check_val("div2_locked_not_yet", int'(locked), 0);
                check_val("div2_meas_div", int'(meas_div), 2);
            end
            if (i == 9 + LAT) begin
                check_val("div2_locked", int'(locked), 1);
                check_val("div2_valid_pulse", int'(meas_valid), 0);
                check_val("div2_meas_high", int'(meas_high), 1);
            end
        end
        settle();
        check_val("div2_valid_count", n_valid - base_v, 5);
        check_val("div2_no_mismatch", n_mism - base_m, 0);

        // 5/5 pattern with exp 10 locks, then exp 4 fails every period
        restart(8'd10);
        run_pattern(5, 5, 6);
        settle();
        check_val("d10_locked", int'(locked), 1);
        check_val("d10_meas_div", int'(meas_div), 10);
        check_val("d10_meas_high", int'(meas_high), 5);
        check_val("d10_valid_count", n_valid - base_v, 5);
        check_val("d10_no_mismatch", n_mism - base_m, 0);
        exp_div = 8'd4;
        base_m  = n_mism;
        run_pattern(5, 5, 3);
        settle();
        check_val("exp4_mismatch_count", n_mism - base_m, 3);
        check_val("exp4_err_cnt", int'(err_cnt), 3);
        check_val("exp4_unlocked", int'(locked), 0);

        // 3/7 duty fails every check
        restart(8'd10);
        run_pattern(3, 7, 6);
        settle();
        check_val("duty_mismatch_count", n_mism - base_m, 5);
        check_val("duty_err_cnt", int'(err_cnt), 5);
        check_val("duty_locked", int'(locked), 0);
        check_val("duty_meas_div", int'(meas_div), 10);
        check_val("duty_meas_high", int'(meas_high), 3);

        // checking disabled
        restart(8'd0);
        run_pattern(5, 5, 6);
        settle();
        check_val("off_valid_count", n_valid - base_v, 5);
        check_val("off_no_mismatch", n_mism - base_m, 0);
        check_val("off_locked", int'(locked), 0);
        check_val("off_meas_div", int'(meas_div), 10);

        // stall: period counter saturates exactly 255 edges after the last rise
        restart(8'd10);
        run_pattern(5, 5, 6);
        check_val("stall_pre_locked", int'(locked), 1);
        for (int n = 1; n <= 250 + LAT; n++) begin
            div_in = 1'b0;
            step();
            if (n == 245 + LAT) begin
                check_val("stall_edge_before", int'(stall), 0);
                check_val("stall_locked_before", int'(locked), 1);
            end
            if (n == 246 + LAT) begin
                check_val("stall_set", int'(stall), 1);
                check_val("stall_unlocked", int'(locked), 0);
            end
        end
        run_pattern(5, 5, 5);
        check_val("relock", int'(locked), 1);
        check_val("stall_sticky", int'(stall), 1);
        exp_div = 8'd4;
        run_pattern(5, 5, 1);
        settle();
        check_val("relock_err_cnt", int'(err_cnt), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_val("clr_stall", int'(stall), 0);
        check_val("clr_err_cnt", int'(err_cnt), 0);
        check_val("clr_meas_div_hold", int'(meas_div), 10);

        // err_cnt saturation, then clr colliding with a failing check
        restart(8'd4);
        run_pattern(1, 1, 262);
        for (int k = 0; k < 8; k++) begin
            div_in = (k % 2 == 0);
            clr    = (k == 4 + LAT);
            step();
            if (k == 2 + LAT) begin
                check_val("sat_mismatch_pulse", int'(mismatch), 1);
                check_val("sat_err_cnt", int'(err_cnt), 255);
            end
            if (k == 4 + LAT) begin
                check_val("clr_vs_mismatch_pulse", int'(mismatch), 0);
                check_val("clr_vs_mismatch_err", int'(err_cnt), 0);
            end
        end
        clr = 1'b0;
        settle();
        check_val("post_clr_err_cnt", int'(err_cnt), 0);

        // async reset mid-period while locked
        restart(8'd2);
        run_pattern(1, 1, 6);
        check_val("rst_pre_locked", int'(locked), 1);
        #2;
        rstn = 1'b0;
        #1;
        check_val("arst_locked", int'(locked), 0);
        check_val("arst_meas_div", int'(meas_div), 0);
        check_val("arst_meas_high", int'(meas_high), 0);
        @(negedge clk);
        rstn   = 1'b1;
        div_in = 1'b0;
        repeat (3) step();
        base_v = n_valid;
        run_pattern(1, 1, 1);
        settle();
        check_val("arst_first_rise_no_valid", n_valid - base_v, 0);
        run_pattern(1, 1, 1);
        settle();
        check_val("arst_second_rise_valid", n_valid - base_v, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
